shifter_rs_iter32: RTL
======================

// Module: shifter_rs_iter32
// PURPOSE
//   Iterative right shifter (logical or arithmetic) for 32-bit datapath words.
//   Complements the combinational left shifter in the ALU shift unit.
//   Applies one log2 shift stage per clock: a 5-bit shift completes in 5 cycles.
//   Valid/ready on both sides so the ALU control FSM can stall it.
// PARAMETERS
//   N   32  data width in bits
//   S   5   shift-amount width; must equal $clog2(N); also the number of stages
// PORTS
//   clk        in   1  clock; all state updates on rising edge
//   rst_n      in   1  asynchronous, active-low reset
//   in_valid   in   1  request presents a, s, arith
//   in_ready   out  1  block can accept a request (high only in IDLE)
//   a          in   N  operand to shift
//   s          in   S  shift amount, 0..N-1
//   arith      in   1  1 = arithmetic (replicate a[N-1]); 0 = logical (fill 0)
//   out_valid  out  1  y holds a completed result
//   out_ready  in   1  consumer takes the result
//   y          out  N  result, a >> s (logical) or a >>> s (arithmetic)
// BEHAVIOUR
//   Reset (rst_n low, async): state=IDLE, out_valid=0, y=0, step counter=0,
//     captured s and arith cleared. Abort any in-flight op; no result emitted.
//   States: IDLE, SHIFT, DONE.
//   IDLE: in_ready=1. On edge with in_valid&in_ready: y<=a, amount reg<=s,
//     fill reg<=arith&a[N-1], step<=0, go SHIFT. Inputs ignored after capture.
//   SHIFT: in_ready=0, out_valid=0. Each edge for k=step: if amount[k]=1,
//     y<=y shifted right by 2^k, vacated upper 2^k bits = fill; else hold.
//     step<=step+1; after k=S-1 go DONE.
//   DONE: out_valid=1, y stable. On edge with out_ready: go IDLE, out_valid<=0.
//     out_ready low: hold DONE indefinitely, y and out_valid unchanged.
//   Latency fixed: accept at edge T -> out_valid high after edge T+S (5),
//     independent of s value (s=0 still takes S cycles).
//   Throughput: one op per S+2 cycles min (accept, S stages, handoff).
//   in_valid while not IDLE: ignored, no effect, no queuing.
//   out_ready while not DONE: ignored.
//   Fill bit sampled from a at accept; arith=0 always fills 0.
//   Reset asserted in any state returns to IDLE asynchronously; deassert
//     is synchronised externally; first accept possible on first edge after.
//   in_ready is combinational from state only (no path from in_valid).
// TESTING
//   a=0x8000_0000, s=31, arith=0 -> y=0x0000_0001, out_valid 5 cycles after
//     accept edge.
//   a=0x8000_0000, s=31, arith=1 -> y=0xFFFF_FFFF.
//   a=0xDEAD_BEEF, s=0, arith=1 -> y=0xDEAD_BEEF after 5 cycles;
//     a=0x1234_5678, s=4, arith=0 -> y=0x0123_4567;
//     a=0xF000_0000, s=8, arith=1 -> y=0xFFF0_0000.
//   Backpressure: hold out_ready=0 10 cycles in DONE -> y, out_valid stable,
//     in_ready=0; new in_valid pulses during SHIFT/DONE produce no result.
//   Reset mid-SHIFT (rst_n low at cycle 2) -> out_valid=0, y=0, in_ready=1
//     immediately; next op after release gives correct result.
//   Randomised 1000 ops, random a/s/arith/out_ready -> y matches a>>s or
//     $signed(a)>>>s; every accepted op produces exactly one result.

Source files
------------

// File: rtl/shifter_rs_iter32.sv
// Iterative right shifter (logical/arithmetic): one log2 stage per clock,
// valid/ready handshake on both request and result sides.
module shifter_rs_iter32 #(
  parameter int N = 32,
  parameter int S = 5
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] a,
  input  logic [S-1:0] s,
  input  logic         arith,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] y
);

  localparam int CW = (S > 1) ? $clog2(S) : 1;
  localparam logic [CW-1:0] LAST_STEP = CW'(S - 1);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t        state;
  logic [S-1:0]  amount;
  logic          fill;
  logic [CW-1:0] step;

  // Shift right by 2^k, filling the vacated upper bits with f.
  function automatic logic [N-1:0] shift_stage(input logic [N-1:0] v,
                                               input logic [CW-1:0] k,
                                               input logic f);
    logic [N-1:0] ones;
    logic [N-1:0] mask;
    int unsigned  sh;
    ones = '1;
    sh   = 32'd1 << k;
    mask = ~(ones >> sh);
    return (v >> sh) | (f ? mask : '0);
  endfunction

  assign in_ready = (state == IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      out_valid <= 1'b0;
      y         <= '0;
      step      <= '0;
      amount    <= '0;
      fill      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            y      <= a;
            amount <= s;
            fill   <= arith & a[N-1];
            step   <= '0;
            state  <= SHIFT;
          end
        end
        SHIFT: begin
          // s=0 still walks every stage so latency never depends on the data
          if (amount[step])
            y <= shift_stage(y, step, fill);
          step <= step + 1'b1;
          if (step == LAST_STEP) begin
            state     <= DONE;
            out_valid <= 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
          end
        end
        default: begin
          state     <= IDLE;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule
